// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: bus widths, arbiter state encoding and the
// default read data returned when a transfer is ended by the watchdog.
package wb_pkg;

  localparam int WB_DATA_W = 32;
  localparam int WB_ADDR_W = 32;
  localparam int WB_SEL_W  = 4;

  localparam logic [31:0] TIMEOUT_DATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2,
    ST_TMO  = 2'd3
  } wb_state_e;

  function automatic wb_state_e gnt_state(input logic master);
    return master ? ST_GNT1 : ST_GNT0;
  endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Per-transfer wait-for-ack counter; flags a stalled strobe that has waited
// LIMIT cycles without an acknowledge.
module wb_watchdog #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic active_i,
  input  logic restart_i,
  input  logic stb_i,
  input  logic ack_i,
  output logic expired_o
);

  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 16'd1;
    if (!active_i || restart_i || ack_i || !stb_i) cnt_d = '0;
  end

  // A real ack in the limit cycle takes precedence over the timeout.
  assign expired_o = active_i && stb_i && !ack_i && (cnt_q == 16'(LIMIT));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Two-master round-robin Wishbone arbiter with a per-transfer watchdog that
// ends hung accesses with a synthetic ack and a sticky fault flag.
module wb_master_arbiter
  import wb_pkg::*;
#(
  parameter int WB_DATA_WIDTH  = WB_DATA_W,
  parameter int WB_ADDR_WIDTH  = WB_ADDR_W,
  parameter int WB_SEL_WIDTH   = WB_SEL_W,
  parameter int TIMEOUT_CYCLES = 255,
  parameter logic [WB_DATA_WIDTH-1:0] TIMEOUT_DATA = WB_DATA_WIDTH'(TIMEOUT_DATA_DEF)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [WB_ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] m0_data_i,
  input  logic                     m0_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  m0_sel_i,
  input  logic                     m0_stb_i,
  input  logic                     m0_cyc_i,
  output logic                     m0_ack_o,
  output logic [WB_DATA_WIDTH-1:0] m0_data_o,
  input  logic [WB_ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [WB_DATA_WIDTH-1:0] m1_data_i,
  input  logic                     m1_we_i,
  input  logic [WB_SEL_WIDTH-1:0]  m1_sel_i,
  input  logic                     m1_stb_i,
  input  logic                     m1_cyc_i,
  output logic                     m1_ack_o,
  output logic [WB_DATA_WIDTH-1:0] m1_data_o,
  output logic [WB_ADDR_WIDTH-1:0] s_addr_o,
  output logic [WB_DATA_WIDTH-1:0] s_data_o,
  output logic                     s_we_o,
  output logic [WB_SEL_WIDTH-1:0]  s_sel_o,
  output logic                     s_stb_o,
  output logic                     s_cyc_o,
  input  logic                     s_ack_i,
  input  logic [WB_DATA_WIDTH-1:0] s_data_i,
  output logic [1:0]               grant_o,
  output logic                     timeout_o,
  output logic                     timeout_src_o,
  input  logic                     timeout_clr_i
);

  wb_state_e state_q, state_d;
  logic      last_q, last_d;
  logic      timeout_q, timeout_d;
  logic      src_q, src_d;

  logic owner, granted, own_cyc, own_stb, oth_cyc, expired, restart;

  // During TMO the owner is the master that just timed out.
  always_comb begin
    owner = 1'b0;
    if (state_q == ST_GNT1)     owner = 1'b1;
    else if (state_q == ST_TMO) owner = src_q;
  end

  assign granted = (state_q == ST_GNT0) || (state_q == ST_GNT1);
  assign own_cyc = owner ? m1_cyc_i : m0_cyc_i;
  assign own_stb = owner ? m1_stb_i : m0_stb_i;
  assign oth_cyc = owner ? m0_cyc_i : m1_cyc_i;
  assign restart = (state_d != state_q);

  wb_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .active_i (granted),
    .restart_i(restart),
    .stb_i    (own_stb && own_cyc),
    .ack_i    (s_ack_i),
    .expired_o(expired)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    src_d     = src_q;
    timeout_d = timeout_q;
    if (timeout_clr_i) timeout_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_d = last_q ? ST_GNT0 : ST_GNT1;
        else if (m0_cyc_i)        state_d = ST_GNT0;
        else if (m1_cyc_i)        state_d = ST_GNT1;
      end
      ST_GNT0, ST_GNT1: begin
        if (expired) begin
          state_d   = ST_TMO;
          timeout_d = 1'b1;
          src_d     = owner;
        end else if (!own_cyc) begin
          last_d  = owner;
          state_d = oth_cyc ? gnt_state(!owner) : ST_IDLE;
        end
      end
      ST_TMO: begin
        if (own_cyc) begin
          state_d = gnt_state(owner);
        end else begin
          last_d  = owner;
          state_d = oth_cyc ? gnt_state(!owner) : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      last_q    <= 1'b1;
      timeout_q <= 1'b0;
      src_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
      src_q     <= src_d;
    end
  end

  // Request/response paths are pure muxes while granted; TMO aborts the slave.
  always_comb begin
    s_addr_o  = '0;
    s_data_o  = '0;
    s_we_o    = 1'b0;
    s_sel_o   = '0;
    s_stb_o   = 1'b0;
    s_cyc_o   = 1'b0;
    m0_ack_o  = 1'b0;
    m0_data_o = '0;
    m1_ack_o  = 1'b0;
    m1_data_o = '0;
    if (granted && owner) begin
      s_addr_o  = m1_addr_i;
      s_data_o  = m1_data_i;
      s_we_o    = m1_we_i;
      s_sel_o   = m1_sel_i;
      s_stb_o   = m1_stb_i;
      s_cyc_o   = m1_cyc_i;
      m1_ack_o  = s_ack_i;
      m1_data_o = s_data_i;
    end else if (granted) begin
      s_addr_o  = m0_addr_i;
      s_data_o  = m0_data_i;
      s_we_o    = m0_we_i;
      s_sel_o   = m0_sel_i;
      s_stb_o   = m0_stb_i;
      s_cyc_o   = m0_cyc_i;
      m0_ack_o  = s_ack_i;
      m0_data_o = s_data_i;
    end else if (state_q == ST_TMO && owner) begin
      m1_ack_o  = 1'b1;
      m1_data_o = TIMEOUT_DATA;
    end else if (state_q == ST_TMO) begin
      m0_ack_o  = 1'b1;
      m0_data_o = TIMEOUT_DATA;
    end
  end

  always_comb begin
    grant_o = 2'b00;
    if (state_q != ST_IDLE) grant_o = owner ? 2'b10 : 2'b01;
  end

  assign timeout_o     = timeout_q;
  assign timeout_src_o = src_q;

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter: single master, tie, fairness,
// watchdog timeout, clear precedence and reset during a transfer.
module tb_wb_master_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int SW  = 4;
  localparam int TMO = 8;
  localparam logic [31:0] TMO_DATA = 32'hDEAD_BEEF;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [AW-1:0] m0_addr_i, m1_addr_i, s_addr_o;
  logic [DW-1:0] m0_data_i, m1_data_i, m0_data_o, m1_data_o, s_data_o, s_data_i;
  logic          m0_we_i, m1_we_i, s_we_o;
  logic [SW-1:0] m0_sel_i, m1_sel_i, s_sel_o;
  logic          m0_stb_i, m0_cyc_i, m1_stb_i, m1_cyc_i, s_stb_o, s_cyc_o;
  logic          m0_ack_o, m1_ack_o, s_ack_i;
  logic [1:0]    grant_o;
  logic          timeout_o, timeout_src_o, timeout_clr_i;

  int n_assert = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  wb_master_arbiter #(
    .WB_DATA_WIDTH (DW),
    .WB_ADDR_WIDTH (AW),
    .WB_SEL_WIDTH  (SW),
    .TIMEOUT_CYCLES(TMO),
    .TIMEOUT_DATA  (TMO_DATA)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_addr_i(m0_addr_i), .m0_data_i(m0_data_i), .m0_we_i(m0_we_i),
    .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i), .m0_cyc_i(m0_cyc_i),
    .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
    .m1_addr_i(m1_addr_i), .m1_data_i(m1_data_i), .m1_we_i(m1_we_i),
    .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i), .m1_cyc_i(m1_cyc_i),
    .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
    .s_addr_o(s_addr_o), .s_data_o(s_data_o), .s_we_o(s_we_o),
    .s_sel_o(s_sel_o), .s_stb_o(s_stb_o), .s_cyc_o(s_cyc_o),
    .s_ack_i(s_ack_i), .s_data_i(s_data_i),
    .grant_o(grant_o), .timeout_o(timeout_o),
    .timeout_src_o(timeout_src_o), .timeout_clr_i(timeout_clr_i)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  // Master m: cyc/stb level and address; master 1 issues writes, master 0 reads.
  task automatic set_m(input int m, input logic req, input logic [AW-1:0] addr);
    if (m == 0) begin
      m0_cyc_i = req; m0_stb_i = req; m0_addr_i = addr;
      m0_we_i = 1'b0; m0_sel_i = 4'hF; m0_data_i = '0;
    end else begin
      m1_cyc_i = req; m1_stb_i = req; m1_addr_i = addr;
      m1_we_i = req; m1_sel_i = 4'h3; m1_data_i = addr ^ 32'h5A5A_0000;
    end
  endtask

  task automatic expect_ack(input string tag, input int m);
    logic [DW-1:0] e;
    chk({tag, "_ack"}, (m == 1) ? m1_ack_o : m0_ack_o, 32'd1);
    chk({tag, "_other_ack"}, (m == 1) ? m0_ack_o : m1_ack_o, 32'd0);
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s_sb: observed empty queue expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_data"}, (m == 1) ? m1_data_o : m0_data_o, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [DW-1:0] d;
    int o, cnt;
    rst_ni = 1'b0; s_ack_i = 1'b0; s_data_i = '0; timeout_clr_i = 1'b0;
    set_m(0, 1'b0, '0);
    set_m(1, 1'b0, '0);
    #3;
    chk("rst_s_cyc", s_cyc_o, 0);
    chk("rst_s_stb", s_stb_o, 0);
    chk("rst_grant", grant_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_src", timeout_src_o, 0);
    chk("rst_acks", {m0_ack_o, m1_ack_o}, 0);
    tick(); tick();
    rst_ni = 1'b1;

    // Single master read, slave acks in the third granted cycle
    tick(); set_m(0, 1'b1, 32'h10); settle();
    chk("t1_cyc_latency", s_cyc_o, 0);
    chk("t1_grant_idle", grant_o, 0);
    tick(); settle();
    chk("t1_cyc", s_cyc_o, 1);
    chk("t1_addr", s_addr_o, 32'h10);
    chk("t1_grant", grant_o, 2'b01);
    chk("t1_m1_ack", m1_ack_o, 0);
    tick(); settle();
    chk("t1_wait_ack", m0_ack_o, 0);
    tick(); d = $urandom; s_ack_i = 1'b1; s_data_i = d; exp_q.push_back(d); settle();
    expect_ack("t1", 0);
    chk("t1_m1_data", m1_data_o, 0);
    tick(); s_ack_i = 1'b0; set_m(0, 1'b0, '0); settle();
    chk("t1_rel_grant", grant_o, 2'b01);
    chk("t1_rel_cyc", s_cyc_o, 0);
    tick(); settle();
    chk("t1_idle", grant_o, 0);

    // Tie right after reset goes to master 0, then direct handover
    rst_ni = 1'b0; tick(); rst_ni = 1'b1;
    set_m(0, 1'b1, 32'h100); set_m(1, 1'b1, 32'h200);
    tick(); settle();
    chk("t2_first_grant", grant_o, 2'b01);
    chk("t2_first_addr", s_addr_o, 32'h100);
    d = $urandom; s_ack_i = 1'b1; s_data_i = d; exp_q.push_back(d); settle();
    expect_ack("t2_m0", 0);
    tick(); s_ack_i = 1'b0; set_m(0, 1'b0, '0); settle();
    chk("t2_gap_cyc", s_cyc_o, 0);
    tick(); settle();
    chk("t2_handover", grant_o, 2'b10);
    chk("t2_m1_addr", s_addr_o, 32'h200);
    chk("t2_m1_we", s_we_o, 1);
    chk("t2_m1_wdata", s_data_o, 32'h200 ^ 32'h5A5A_0000);
    d = $urandom; s_ack_i = 1'b1; s_data_i = d; exp_q.push_back(d); settle();
    expect_ack("t2_m1", 1);
    tick(); s_ack_i = 1'b0; set_m(1, 1'b0, '0);
    tick(); settle();
    chk("t2_idle", grant_o, 0);

    // Both masters request continuously: grants must alternate
    set_m(0, 1'b1, 32'h1000); set_m(1, 1'b1, 32'h2000);
    tick();
    for (int i = 0; i < 6; i++) begin
      o = i % 2;
      settle();
      chk("t3_grant", grant_o, (o == 1) ? 2'b10 : 2'b01);
      chk("t3_we", s_we_o, o);
      d = $urandom; s_ack_i = 1'b1; s_data_i = d; exp_q.push_back(d); settle();
      expect_ack("t3", o);
      tick(); s_ack_i = 1'b0; set_m(o, 1'b0, '0);
      if (i == 5) set_m(1 - o, 1'b0, '0);
      tick();
      if (i < 5) set_m(o, 1'b1, (o == 1) ? 32'h2000 : 32'h1000);
    end
    settle();
    chk("t3_idle", grant_o, 0);

    // Master 1 stalls: watchdog ack TMO+1 cycles after grant
    set_m(1, 1'b1, 32'h300); s_data_i = 32'h1111_2222;
    tick(); settle();
    chk("t4_grant", grant_o, 2'b10);
    chk("t4_no_ack", m1_ack_o, 0);
    exp_q.push_back(TMO_DATA);
    cnt = 0;
    while (!m1_ack_o && cnt < 20) begin
      tick();
      cnt++;
    end
    chk("t4_latency", cnt, TMO + 1);
    expect_ack("t4", 1);
    chk("t4_s_stb", s_stb_o, 0);
    chk("t4_s_cyc", s_cyc_o, 0);
    chk("t4_timeout", timeout_o, 1);
    chk("t4_src", timeout_src_o, 1);
    chk("t4_grant_tmo", grant_o, 2'b10);
    set_m(1, 1'b0, '0);
    tick(); settle();
    chk("t4_idle", grant_o, 0);
    chk("t4_sticky", timeout_o, 1);

    // Clear coincides with a new timeout on master 0: set wins
    set_m(0, 1'b1, 32'h400);
    tick();
    for (int c = 1; c <= TMO; c++) tick();
    chk("t5_no_ack_yet", m0_ack_o, 0);
    timeout_clr_i = 1'b1;
    exp_q.push_back(TMO_DATA);
    tick(); timeout_clr_i = 1'b0; settle();
    expect_ack("t5", 0);
    chk("t5_set_wins", timeout_o, 1);
    chk("t5_src", timeout_src_o, 0);
    set_m(0, 1'b0, '0);
    tick(); timeout_clr_i = 1'b1; settle();
    chk("t5_before_clr", timeout_o, 1);
    tick(); timeout_clr_i = 1'b0; settle();
    chk("t5_cleared", timeout_o, 0);

    // Reset mid-transfer drops the slave request at once
    set_m(0, 1'b1, 32'h500);
    tick(); tick(); settle();
    chk("t6_granted", grant_o, 2'b01);
    chk("t6_cyc", s_cyc_o, 1);
    rst_ni = 1'b0; s_ack_i = 1'b1; settle();
    chk("t6_rst_cyc", s_cyc_o, 0);
    chk("t6_rst_stb", s_stb_o, 0);
    chk("t6_rst_grant", grant_o, 0);
    chk("t6_rst_ack", {m0_ack_o, m1_ack_o}, 0);
    chk("t6_rst_data", m0_data_o, 0);
    tick(); s_ack_i = 1'b0; set_m(1, 1'b1, 32'h600); rst_ni = 1'b1;
    tick(); settle();
    chk("t6_tie_after_rst", grant_o, 2'b01);
    set_m(0, 1'b0, '0); set_m(1, 1'b0, '0);
    tick(); tick();

    chk("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
